// File: rtl/spi_master_tx.sv
// SPI mode-0 master: transmits one DATA_W-bit word MSB first while
// capturing miso, framing it with a lead and trail half-period on cs_n.
module spi_master_tx #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              clk_100,
    input  logic              a_rst,
    input  logic              s_rst,
    input  logic              start_send,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

    state_e            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_q, cs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-2:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] rxo_q, rxo_d;
    logic              tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk_100 or posedge a_rst) begin
        if (a_rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxo_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxo_q   <= rxo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxo_d   = rxo_q;
        unique case (state_q)
            IDLE: begin
                if (start_send) begin
                    tx_d    = tx_data[DATA_W-2:0];
                    mosi_d  = tx_data[DATA_W-1];
                    cs_d    = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[DATA_W-2:0], miso};
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!tick) begin
                    div_d = div_q + 8'd1;
                end else if (sclk_q) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q != BIT_LAST) begin
                        mosi_d = tx_q[DATA_W-2];
                        tx_d   = tx_q << 1;
                    end
                end else if (bit_q == BIT_LAST) begin
                    // one full low half-period after the last fall
                    div_d   = '0;
                    cs_d    = 1'b1;
                    state_d = TRAIL;
                end else begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                    bit_d  = bit_q + BW'(1);
                    rx_d   = {rx_q[DATA_W-2:0], miso};
                end
            end
            TRAIL: begin
                if (tick) begin
                    div_d   = '0;
                    bit_d   = '0;
                    done_d  = 1'b1;
                    rxo_d   = rx_q;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
        endcase
        if (s_rst) begin
            state_d = IDLE;
            div_d   = '0;
            bit_d   = '0;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            cs_d    = 1'b1;
            done_d  = 1'b0;
            tx_d    = '0;
            rx_d    = '0;
            rxo_d   = '0;
        end
        busy_d = (state_d != IDLE);
    end

    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rxo_q;

endmodule
